// File: rtl/rand_pkg.sv
// rand_pkg -- shared definitions for the random-number scheduler.
//   LFSR_W      : width of the free-running LFSR and of delivered values
//   LIM_W       : width of one per-requester limit slice
//   state_e     : scheduler FSM encoding
//   lim_accept(): rejection-sampling acceptance test for one draw
package rand_pkg;

  localparam int LFSR_W = 4;
  localparam int LIM_W  = 5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SAMPLE  = 2'd1,
    ST_DELIVER = 2'd2
  } state_e;

  // A limit of 0, or any value with the top bit set (>= 16), places no
  // bound on a 4-bit draw. Otherwise the limit is an exclusive upper bound.
  function automatic logic lim_accept(input logic [LFSR_W-1:0] v,
                                      input logic [LIM_W-1:0]  lim);
    return (lim == '0) || lim[LIM_W-1] || ({1'b0, v} < lim);
  endfunction

endpackage

// File: rtl/rand_scheduler_lfsr4.sv
// lfsr4 -- free-running 4-bit XNOR LFSR.
//   clk     : clock, advances on every rising edge
//   reset_n : asynchronous active-low reset, clears the register to 0
//   q       : current LFSR value
// XNOR feedback makes all-zeros a legal state, so the register can reset
// to 0; the lock-up value is 15, which the sequence never reaches.
// Sequence: 0,1,3,7,14,13,11,6,12,9,2,5,10,4,8 (period 15).
module lfsr4
  import rand_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  output logic [LFSR_W-1:0] q
);

  logic [LFSR_W-1:0] q_q;
  logic [LFSR_W-1:0] q_d;

  assign q_d = {q_q[2:0], ~(q_q[3] ^ q_q[2])};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) q_q <= '0;
    else          q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/rand_scheduler.sv
// rand_scheduler -- shares one LFSR among NUM_REQ requesters. A round-robin
// winner is latched in IDLE, bounded random values are produced by
// rejection sampling in SAMPLE, and a one-cycle grant is issued in DELIVER.
//   clk       : clock, all state on rising edge
//   reset_n   : asynchronous active-low reset
//   req       : per-requester request level, held until its grant
//   limit     : packed per-requester exclusive bound, slice i = limit[5i+4:5i]
//               (0 or >= 16 means unbounded)
//   gnt       : one-hot grant pulse, one cycle
//   valid     : high exactly when gnt is non-zero
//   rand_out  : delivered value, held until the next delivery
//   exhausted : with valid, MAX_TRIES rejections occurred and rand_out is 0
module rand_scheduler
  import rand_pkg::*;
#(
  parameter int NUM_REQ   = 3,
  parameter int MAX_TRIES = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [LIM_W*NUM_REQ-1:0] limit,
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     valid,
  output logic [LFSR_W-1:0]        rand_out,
  output logic                     exhausted
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TRY_W = $clog2(MAX_TRIES + 1);

  logic [NUM_REQ-1:0][LIM_W-1:0] lim_arr;
  assign lim_arr = limit;

  // Random source
  logic [LFSR_W-1:0] lfsr;

  lfsr4 u_lfsr (
    .clk    (clk),
    .reset_n(reset_n),
    .q      (lfsr)
  );

  // State
  state_e            state_q, state_d;
  logic [IDX_W-1:0]  ptr_q,   ptr_d;
  logic [IDX_W-1:0]  win_q,   win_d;
  logic [LIM_W-1:0]  lim_q,   lim_d;
  logic [TRY_W-1:0]  try_q,   try_d;
  logic [LFSR_W-1:0] rnd_q,   rnd_d;
  logic              exh_q,   exh_d;

  // Round-robin pick: scan offsets from farthest to nearest so the nearest
  // pending requester at or above ptr (with wrap) is the last one written.
  logic             pick_vld;
  logic [IDX_W-1:0] pick_idx;

  always_comb begin
    int               idx;
    logic [IDX_W-1:0] cand;
    pick_vld = 1'b0;
    pick_idx = ptr_q;
    idx      = 0;
    cand     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = IDX_W'(idx);
      if (req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    lim_d   = lim_q;
    try_d   = try_q;
    rnd_d   = rnd_q;
    exh_d   = exh_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          win_d   = pick_idx;
          lim_d   = lim_arr[pick_idx];
          try_d   = '0;
          exh_d   = 1'b0;
          state_d = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        if (lim_accept(lfsr, lim_q)) begin
          rnd_d   = lfsr;
          exh_d   = 1'b0;
          state_d = ST_DELIVER;
        end else if (try_q == TRY_W'(MAX_TRIES - 1)) begin
          // This reject is the last allowed one: give up with a zero value.
          try_d   = try_q + 1'b1;
          rnd_d   = '0;
          exh_d   = 1'b1;
          state_d = ST_DELIVER;
        end else begin
          try_d   = try_q + 1'b1;
        end
      end
      ST_DELIVER: begin
        ptr_d   = (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      lim_q   <= '0;
      try_q   <= '0;
      rnd_q   <= '0;
      exh_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      lim_q   <= lim_d;
      try_q   <= try_d;
      rnd_q   <= rnd_d;
      exh_q   <= exh_d;
    end
  end

  // Moore outputs of DELIVER; reset forces IDLE so they drop immediately.
  always_comb begin
    gnt       = '0;
    valid     = 1'b0;
    exhausted = 1'b0;
    if (state_q == ST_DELIVER) begin
      gnt[win_q] = 1'b1;
      valid      = 1'b1;
      exhausted  = exh_q;
    end
  end

  assign rand_out = rnd_q;

endmodule

// File: tb/tb_rand_scheduler.sv
// tb_rand_scheduler -- directed bench for rand_scheduler (NUM_REQ=3,
// MAX_TRIES=8). Expected values are hand-derived from the LFSR sequence
// 0,1,3,7,14,13,11,6,12,9,2,5,... counted from the edge after reset release.
module tb_rand_scheduler;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  req = '0;
  logic [14:0] limit = '0;
  logic [2:0]  gnt;
  logic        valid;
  logic [3:0]  rand_out;
  logic        exhausted;

  int ncmp = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  rand_scheduler #(.NUM_REQ(3), .MAX_TRIES(8)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req      (req),
    .limit    (limit),
    .gnt      (gnt),
    .valid    (valid),
    .rand_out (rand_out),
    .exhausted(exhausted)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset, then release on a falling edge; the next rising edge is edge 1.
  task automatic start();
    reset_n = 1'b0;
    req     = '0;
    limit   = '0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic set_lim(input int i, input logic [4:0] v);
    limit[5*i +: 5] = v;
  endtask

  initial begin
    logic [2:0] eg;
    logic [3:0] er;
    logic [2:0] last_g;
    int         w;
    int         cnt;

    // Reset state
    #2;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_rand", 32'(rand_out), 0);
    chk("rst_exh", 32'(exhausted), 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Best-case latency: first draw after reset is 1
    req = 3'b001;
    tick();
    chk("s1_e1_gnt", 32'(gnt), 0);
    tick();
    chk("s1_e2_gnt", 32'(gnt), 32'h1);
    chk("s1_e2_valid", 32'(valid), 1);
    chk("s1_e2_rand", 32'(rand_out), 1);
    chk("s1_e2_exh", 32'(exhausted), 0);
    req = 3'b000;
    tick();
    chk("s1_e3_gnt", 32'(gnt), 0);
    chk("s1_e3_valid", 32'(valid), 0);
    chk("s1_e3_hold", 32'(rand_out), 1);

    // Round robin with all requesters pending, unbounded limits
    start();
    req = 3'b111;
    for (int e = 1; e <= 12; e++) begin
      tick();
      case (e)
        2:       begin eg = 3'b001; er = 4'd1;  end
        5:       begin eg = 3'b010; er = 4'd14; end
        8:       begin eg = 3'b100; er = 4'd6;  end
        11:      begin eg = 3'b001; er = 4'd2;  end
        default: begin eg = 3'b000; er = 4'd0;  end
      endcase
      chk($sformatf("s2_gnt_e%0d", e), 32'(gnt), 32'(eg));
      chk($sformatf("s2_valid_e%0d", e), 32'(valid), 32'(eg != 0));
      if (eg != 0) chk($sformatf("s2_rand_e%0d", e), 32'(rand_out), 32'(er));
    end
    req = 3'b000;

    // Exhaustion: limit 1 accepts only 0, which is not drawn in 8 tries
    start();
    req = 3'b001;
    tick();
    tick();
    chk("s3_pre_gnt", 32'(gnt), 32'h1);
    chk("s3_pre_rand", 32'(rand_out), 1);
    chk("s3_pre_exh", 32'(exhausted), 0);
    set_lim(0, 5'd1);
    for (int e = 3; e <= 11; e++) begin
      tick();
      chk($sformatf("s3_nogrant_e%0d", e), 32'(gnt), 0);
    end
    tick();
    chk("s3_gnt", 32'(gnt), 32'h1);
    chk("s3_valid", 32'(valid), 1);
    chk("s3_exh", 32'(exhausted), 1);
    chk("s3_rand", 32'(rand_out), 0);
    req = 3'b000;
    tick();
    chk("s3_exh_clr", 32'(exhausted), 0);
    chk("s3_valid_clr", 32'(valid), 0);

    // Bounded draws: limit 8 over 200 grants
    start();
    req = 3'b001;
    set_lim(0, 5'd8);
    for (int g = 0; g < 200; g++) begin
      w = 0;
      do begin tick(); w++; end while (!valid && w < 20);
      chk("s4_wait", 32'(valid), 1);
      chk("s4_lt8", 32'(rand_out < 4'd8), 1);
      chk("s4_not15", 32'(rand_out == 4'd15), 0);
    end
    // Other limits, including unbounded encodings: never 15
    for (int g = 0; g < 60; g++) begin
      case (g % 4)
        0: set_lim(0, 5'd0);
        1: set_lim(0, 5'd16);
        2: set_lim(0, 5'd31);
        default: set_lim(0, 5'd5);
      endcase
      w = 0;
      do begin tick(); w++; end while (!valid && w < 20);
      chk("s4b_wait", 32'(valid), 1);
      chk("s4b_not15", 32'(rand_out == 4'd15), 0);
      if ((g % 4) == 3) chk("s4b_lt5", 32'(rand_out < 4'd5), 1);
    end
    req = 3'b000;

    // Asynchronous reset while sampling
    start();
    req = 3'b001;
    tick();
    tick();
    chk("s5_pre_rand", 32'(rand_out), 1);
    set_lim(0, 5'd1);
    tick();
    tick();
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk("s5_async_gnt", 32'(gnt), 0);
    chk("s5_async_valid", 32'(valid), 0);
    chk("s5_async_rand", 32'(rand_out), 0);
    chk("s5_async_exh", 32'(exhausted), 0);
    tick();
    chk("s5_inrst_gnt1", 32'(gnt), 0);
    tick();
    chk("s5_inrst_gnt2", 32'(gnt), 0);
    @(negedge clk);
    reset_n = 1'b1;
    req     = 3'b000;
    limit   = '0;
    for (int e = 1; e <= 3; e++) begin
      tick();
      chk($sformatf("s5_noabort_e%0d", e), 32'(gnt), 0);
    end
    req = 3'b001;
    tick();
    chk("s5_e4_gnt", 32'(gnt), 0);
    tick();
    chk("s5_e5_gnt", 32'(gnt), 32'h1);
    chk("s5_e5_rand", 32'(rand_out), 14);
    req = 3'b000;

    // Request dropped after being latched still completes once
    start();
    req = 3'b001;
    set_lim(0, 5'd1);
    tick();
    tick();
    req    = 3'b000;
    cnt    = 0;
    last_g = '0;
    for (int e = 3; e <= 16; e++) begin
      tick();
      if (gnt != 0) begin
        cnt++;
        last_g = gnt;
      end
    end
    chk("s6_count", 32'(cnt), 1);
    chk("s6_gnt", 32'(last_g), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
